// File: rtl/reg_file_responder.sv
// Register-file responder: captures read/write request edges from Control and services them with
// a 3-state FSM. Optional `ZERO_REG_EN makes register 0 read as zero and discards writes to it.
module reg_file_responder #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        RegSelect,
  input  logic              ReadFlag,
  input  logic              WriteFlag,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] OperandA,
  output logic [DATA_W-1:0] OperandB,
  output logic [1:0]        DoneRegFlag,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
  } rd_req_t;

  typedef struct packed {
    logic [2:0]        rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state, state_nxt;
  logic              read_prev, write_prev;
  logic              read_pend, write_pend;
  logic              read_acc, write_acc;
  logic              read_clr, write_clr;
  rd_req_t           rd_req;
  wr_req_t           wr_req;
  logic              reg_we;
  logic [DATA_W-1:0] a_val, b_val;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // An edge is only accepted into an empty one-deep slot; otherwise it is dropped.
  assign read_acc  = ReadFlag  & ~read_prev  & ~read_pend;
  assign write_acc = WriteFlag & ~write_prev & ~write_pend;

  always_comb begin
    state_nxt = state;
    read_clr  = 1'b0;
    write_clr = 1'b0;
    case (state)
      IDLE: begin
        if (write_pend) begin
          state_nxt = WRITE;
          write_clr = 1'b1;
        end else if (read_pend) begin
          state_nxt = READ;
          read_clr  = 1'b1;
        end
      end
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_val = regs[rd_req.rs];
    b_val = regs[rd_req.rt];
`ifdef ZERO_REG_EN
    if (rd_req.rs == 3'd0) a_val = '0;
    if (rd_req.rt == 3'd0) b_val = '0;
`endif
  end

`ifdef ZERO_REG_EN
  assign reg_we = (state == WRITE) && (wr_req.rd != 3'd0);
`else
  assign reg_we = (state == WRITE);
`endif

  assign Busy = (state != IDLE) | read_pend | write_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      read_prev   <= 1'b0;
      write_prev  <= 1'b0;
      read_pend   <= 1'b0;
      write_pend  <= 1'b0;
      rd_req      <= '0;
      wr_req      <= '0;
      OperandA    <= '0;
      OperandB    <= '0;
      DoneRegFlag <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state      <= state_nxt;
      read_prev  <= ReadFlag;
      write_prev <= WriteFlag;

      if (read_acc) begin
        read_pend <= 1'b1;
        rd_req    <= '{rs: RegSelect[5:3], rt: RegSelect[2:0]};
      end else if (read_clr) begin
        read_pend <= 1'b0;
      end

      if (write_acc) begin
        write_pend <= 1'b1;
        wr_req     <= '{rd: RegSelect[8:6], data: WriteData};
      end else if (write_clr) begin
        write_pend <= 1'b0;
      end

      if (reg_we) regs[wr_req.rd] <= wr_req.data;

      if (state == READ) begin
        OperandA <= a_val;
        OperandB <= b_val;
      end

      // Done pulses trail the service state by one cycle; states are exclusive so bits never overlap.
      DoneRegFlag <= {state == WRITE, state == READ};
    end
  end

endmodule

// File: tb/tb_reg_file_responder.sv
// Directed table-driven bench for reg_file_responder plus hand-written held-flag and reset-abort sequences.
module tb_reg_file_responder;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [8:0]        RegSelect;
  logic              ReadFlag, WriteFlag;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] OperandA, OperandB;
  logic [1:0]        DoneRegFlag;
  logic              Busy;

  int checks   = 0;
  int failures = 0;

  reg_file_responder #(.DATA_W(DATA_W), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .RegSelect(RegSelect), .ReadFlag(ReadFlag),
    .WriteFlag(WriteFlag), .WriteData(WriteData), .OperandA(OperandA),
    .OperandB(OperandB), .DoneRegFlag(DoneRegFlag), .Busy(Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  rd_idx;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] wdata;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Raise flags for one cycle (cycle N), then check done pulses over N+1..N+6 and operands.
  task automatic do_op(input vec_t v, input int idx);
    logic [1:0] exp_done;
    @(posedge clk); #1;
    RegSelect = {v.rd_idx, v.rs, v.rt};
    WriteData = v.wdata;
    WriteFlag = v.wr;
    ReadFlag  = v.rd;
    @(posedge clk); #1;
    WriteFlag = 1'b0;
    ReadFlag  = 1'b0;
    RegSelect = 9'($urandom);
    WriteData = 16'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_done = 2'b00;
      if (v.wr && c == 3) exp_done[1] = 1'b1;
      if (v.rd && c == (v.wr ? 5 : 3)) exp_done[0] = 1'b1;
      chk($sformatf("vec%0d done c%0d", idx, c), 32'(DoneRegFlag), 32'(exp_done));
      if (c == 1) chk($sformatf("vec%0d busy c1", idx), 32'(Busy), 32'd1);
    end
    chk($sformatf("vec%0d busy idle", idx), 32'(Busy), 32'd0);
    if (v.rd) begin
      chk($sformatf("vec%0d OperandA", idx), 32'(OperandA), 32'(v.exp_a));
      chk($sformatf("vec%0d OperandB", idx), 32'(OperandB), 32'(v.exp_b));
    end
  endtask

  initial begin
    int         pulses;
    logic [15:0] zero_exp;
`ifdef ZERO_REG_EN
    zero_exp = 16'h0000;
`else
    zero_exp = 16'hFFFF;
`endif
    //          wr    rd    rd_idx rs    rt    wdata     exp_a     exp_b
    vecs[0] = '{1'b0, 1'b1, 3'd0, 3'd3, 3'd5, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 16'h1234, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 3'd2, 3'd5, 16'h0000, 16'h1234, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 3'd4, 3'd4, 3'd2, 16'hBEEF, 16'hBEEF, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 3'd7, 3'd0, 3'd0, 16'hA5A5, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 3'd0, 3'd7, 3'd4, 16'h0000, 16'hA5A5, 16'hBEEF};
    vecs[6] = '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 16'h0000, zero_exp, 16'h1234};

    reset = 1'b1; RegSelect = '0; ReadFlag = 1'b0; WriteFlag = 1'b0; WriteData = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset OperandA", 32'(OperandA), 32'd0);
    chk("reset OperandB", 32'(OperandB), 32'd0);
    chk("reset done", 32'(DoneRegFlag), 32'd0);
    chk("reset busy", 32'(Busy), 32'd0);

    for (int i = 0; i < 8; i++) do_op(vecs[i], i);

    // Held ReadFlag: one pulse only, Busy drops at N+3.
    @(posedge clk); #1;
    RegSelect = {3'd0, 3'd7, 3'd2};
    ReadFlag  = 1'b1;
    pulses = 0;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (DoneRegFlag[0]) pulses++;
      if (c == 3) begin
        chk("hold done N+3", 32'(DoneRegFlag), 32'd1);
        chk("hold busy N+3", 32'(Busy), 32'd0);
      end
      if (c == 11) chk("hold busy late", 32'(Busy), 32'd0);
      if (c == 9) ReadFlag = 1'b0;
    end
    chk("hold pulse count", 32'(pulses), 32'd1);
    chk("hold OperandA", 32'(OperandA), 32'hA5A5);

    // Reset asserted during the WRITE cycle aborts the write.
    @(posedge clk); #1;
    RegSelect = {3'd6, 3'd0, 3'd0};
    WriteData = 16'h7777;
    WriteFlag = 1'b1;
    @(posedge clk); #1;
    WriteFlag = 1'b0;
    @(posedge clk); #1;
    chk("abort busy in WRITE", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (DoneRegFlag != 2'b00) pulses++;
    end
    chk("abort no done", 32'(pulses), 32'd0);
    chk("abort busy", 32'(Busy), 32'd0);
    do_op('{1'b0, 1'b1, 3'd0, 3'd6, 3'd2, 16'h0000, 16'h0000, 16'h0000}, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
